// File: rtl/spi_master_core_pkg.sv
// -----------------------------------------------------------------------------
// spi_master_core_pkg
// Shared constants, types and small helpers for the SPI master core.
//   EDGE_CNT_W      : width of the SPI clock edge counter
//   EDGES_PER_BYTE  : SPI clock edges per byte (8 leading + 8 trailing)
//   mode_cpol/cpha  : decode CPOL/CPHA from the two-bit SPI mode number
// -----------------------------------------------------------------------------
package spi_master_core_pkg;

    localparam int unsigned EDGE_CNT_W = 5;

    typedef logic [EDGE_CNT_W-1:0] edge_cnt_t;
    typedef logic [2:0]            bit_idx_t;

    localparam edge_cnt_t EDGES_PER_BYTE = 5'd16;
    localparam edge_cnt_t EDGE_NONE      = 5'd0;
    localparam edge_cnt_t EDGE_ONE       = 5'd1;

    localparam bit_idx_t BIT_IDX_MSB = 3'd7;
    localparam bit_idx_t BIT_IDX_NXT = 3'd6;
    localparam bit_idx_t BIT_IDX_LSB = 3'd0;
    localparam bit_idx_t BIT_IDX_ONE = 3'd1;

    // Clock polarity: idle level of the SPI clock.
    function automatic logic mode_cpol(input logic [1:0] mode);
        return mode[1];
    endfunction

    // Clock phase: 0 = sample on leading edge, 1 = sample on trailing edge.
    function automatic logic mode_cpha(input logic [1:0] mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_master_core.sv
// -----------------------------------------------------------------------------
// spi_master_core
// Single-byte, full-duplex SPI master (all four SPI modes). Chip select is
// handled outside this block.
//
// Parameters
//   SPI_MODE          : 0..3, CPOL = SPI_MODE[1], CPHA = SPI_MODE[0]
//   CLKS_PER_HALF_BIT : i_Clk cycles per SPI clock half period (>= 2)
//
// Ports
//   i_Clk       in   system clock, rising edge
//   i_Rst_L     in   asynchronous active-low reset
//   i_TX_Byte   in   byte to send, MSB first
//   i_TX_DV     in   one-cycle start strobe, honoured only while o_TX_Ready
//   o_TX_Ready  out  idle and able to accept a new byte
//   o_RX_DV     out  one-cycle strobe, o_RX_Byte freshly valid
//   o_RX_Byte   out  last byte received on MISO
//   o_SPI_Clk   out  SPI clock, idles at CPOL
//   i_SPI_MISO  in   serial data from slave
//   o_SPI_MOSI  out  serial data to slave, holds last bit when idle
// -----------------------------------------------------------------------------
module spi_master_core
    import spi_master_core_pkg::*;
#(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_SPI_Clk,
    input  logic       i_SPI_MISO,
    output logic       o_SPI_MOSI
);

    localparam logic CPOL = mode_cpol(2'(SPI_MODE));
    localparam logic CPHA = mode_cpha(2'(SPI_MODE));

    localparam int HALF_CNT_W = $clog2(2 * CLKS_PER_HALF_BIT);
    localparam logic [HALF_CNT_W-1:0] HALF_ZERO = HALF_CNT_W'(0);
    localparam logic [HALF_CNT_W-1:0] HALF_ONE  = HALF_CNT_W'(1);
    // Count value at which the leading edge fires (end of first half period)
    localparam logic [HALF_CNT_W-1:0] HALF_MID  = HALF_CNT_W'(CLKS_PER_HALF_BIT - 1);
    // Count value at which the trailing edge fires (end of full period)
    localparam logic [HALF_CNT_W-1:0] HALF_END  = HALF_CNT_W'(2 * CLKS_PER_HALF_BIT - 1);

    // Clock generator state
    logic                  tx_ready_r;
    edge_cnt_t             edge_cnt_r;
    logic [HALF_CNT_W-1:0] half_cnt_r;
    logic                  spi_clk_r;
    logic                  leading_r;
    logic                  trailing_r;

    // Data path state
    logic [7:0] tx_byte_r;
    bit_idx_t   tx_bit_idx_r;
    logic       mosi_r;
    bit_idx_t   rx_bit_idx_r;
    logic [6:0] rx_shift_r;
    logic [7:0] rx_byte_r;
    logic       rx_dv_r;

    // Decoded strobes
    logic accept_s;
    logic shift_out_s;
    logic sample_in_s;

    // Start acceptance and per-mode shift/sample edge selection.
    always_comb begin
        accept_s    = 1'b0;
        shift_out_s = 1'b0;
        sample_in_s = 1'b0;
        accept_s    = i_TX_DV & tx_ready_r;
        // CPHA=0 puts bit 7 out at start, so the final trailing edge (edge
        // count already back at zero) must not shift another bit out.
        shift_out_s = CPHA ? leading_r : (trailing_r & (edge_cnt_r != EDGE_NONE));
        sample_in_s = CPHA ? trailing_r : leading_r;
    end

    // SPI clock generator: edge counter, half-bit counter and ready flag.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tx_ready_r <= 1'b0;
            edge_cnt_r <= EDGE_NONE;
            half_cnt_r <= HALF_ZERO;
            spi_clk_r  <= CPOL;
            leading_r  <= 1'b0;
            trailing_r <= 1'b0;
        end else begin
            leading_r  <= 1'b0;
            trailing_r <= 1'b0;
            if (accept_s) begin
                tx_ready_r <= 1'b0;
                edge_cnt_r <= EDGES_PER_BYTE;
                half_cnt_r <= HALF_ZERO;
            end else if (edge_cnt_r != EDGE_NONE) begin
                tx_ready_r <= 1'b0;
                if (half_cnt_r == HALF_END) begin
                    edge_cnt_r <= edge_cnt_r - EDGE_ONE;
                    trailing_r <= 1'b1;
                    half_cnt_r <= HALF_ZERO;
                    spi_clk_r  <= ~spi_clk_r;
                end else if (half_cnt_r == HALF_MID) begin
                    edge_cnt_r <= edge_cnt_r - EDGE_ONE;
                    leading_r  <= 1'b1;
                    half_cnt_r <= half_cnt_r + HALF_ONE;
                    spi_clk_r  <= ~spi_clk_r;
                end else begin
                    half_cnt_r <= half_cnt_r + HALF_ONE;
                end
            end else begin
                tx_ready_r <= 1'b1;
            end
        end
    end

    // Transmit path: latch byte on accept and drive MOSI MSB first.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tx_byte_r    <= 8'h00;
            tx_bit_idx_r <= BIT_IDX_MSB;
            mosi_r       <= 1'b0;
        end else if (accept_s) begin
            tx_byte_r <= i_TX_Byte;
            // CPHA=0 must present bit 7 before the first (sampling) edge.
            if (!CPHA) begin
                mosi_r       <= i_TX_Byte[7];
                tx_bit_idx_r <= BIT_IDX_NXT;
            end else begin
                tx_bit_idx_r <= BIT_IDX_MSB;
            end
        end else if (shift_out_s) begin
            mosi_r       <= tx_byte_r[tx_bit_idx_r];
            tx_bit_idx_r <= tx_bit_idx_r - BIT_IDX_ONE;
        end
    end

    // Receive path: shift MISO in MSB first and flag a completed byte.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_bit_idx_r <= BIT_IDX_MSB;
            rx_shift_r   <= 7'h00;
            rx_byte_r    <= 8'h00;
            rx_dv_r      <= 1'b0;
        end else begin
            rx_dv_r <= 1'b0;
            if (accept_s) begin
                rx_bit_idx_r <= BIT_IDX_MSB;
            end else if (sample_in_s) begin
                rx_shift_r   <= {rx_shift_r[5:0], i_SPI_MISO};
                rx_bit_idx_r <= rx_bit_idx_r - BIT_IDX_ONE;
                if (rx_bit_idx_r == BIT_IDX_LSB) begin
                    rx_byte_r <= {rx_shift_r, i_SPI_MISO};
                    rx_dv_r   <= 1'b1;
                end
            end
        end
    end

    assign o_TX_Ready = tx_ready_r;
    assign o_RX_DV    = rx_dv_r;
    assign o_RX_Byte  = rx_byte_r;
    assign o_SPI_Clk  = spi_clk_r;
    assign o_SPI_MOSI = mosi_r;

endmodule

// File: tb/tb_spi_master_core.sv
// -----------------------------------------------------------------------------
// tb_spi_master_core
// Directed bench for spi_master_core: one mode-0 instance (loopback or a
// simple mode-0 slave model on MISO) and one mode-3 instance (loopback).
// -----------------------------------------------------------------------------
module tb_spi_master_core;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Mode 0 instance signals
    logic [7:0] tx_byte0 = 8'h00;
    logic       tx_dv0   = 1'b0;
    logic       rdy0, rx_dv0, spi_clk0, miso0, mosi0;
    logic [7:0] rx_byte0;

    // Mode 3 instance signals
    logic [7:0] tx_byte3 = 8'h00;
    logic       tx_dv3   = 1'b0;
    logic       rdy3, rx_dv3, spi_clk3, mosi3;
    logic [7:0] rx_byte3;

    // MISO source selection for mode 0 and slave model
    logic        sel_loop   = 1'b1;
    logic [15:0] slave_word = 16'h5433;
    int          fall_base  = 0;
    logic        slave_bit;
    int          slave_k;

    // Monitors (written only by the always blocks below)
    int         rise_cnt0 = 0, fall_cnt0 = 0, dv_cnt0 = 0, dv_cnt3 = 0;
    logic [7:0] mosi_smp0 = 8'h00, mosi_smp3 = 8'h00;
    logic [7:0] rx_last0 = 8'h00, rx_prev0 = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spi_master_core #(.SPI_MODE(0), .CLKS_PER_HALF_BIT(4)) dut0 (
        .i_Clk      (clk),
        .i_Rst_L    (rst_n),
        .i_TX_Byte  (tx_byte0),
        .i_TX_DV    (tx_dv0),
        .o_TX_Ready (rdy0),
        .o_RX_DV    (rx_dv0),
        .o_RX_Byte  (rx_byte0),
        .o_SPI_Clk  (spi_clk0),
        .i_SPI_MISO (miso0),
        .o_SPI_MOSI (mosi0)
    );

    spi_master_core #(.SPI_MODE(3), .CLKS_PER_HALF_BIT(4)) dut3 (
        .i_Clk      (clk),
        .i_Rst_L    (rst_n),
        .i_TX_Byte  (tx_byte3),
        .i_TX_DV    (tx_dv3),
        .o_TX_Ready (rdy3),
        .o_RX_DV    (rx_dv3),
        .o_RX_Byte  (rx_byte3),
        .o_SPI_Clk  (spi_clk3),
        .i_SPI_MISO (mosi3),
        .o_SPI_MOSI (mosi3)
    );

    // Mode-0 slave: bit k of the 16-bit stream, advanced on each falling SCLK
    always_comb begin
        slave_k   = fall_cnt0 - fall_base;
        slave_bit = 1'b0;
        if (slave_k >= 0 && slave_k < 16) slave_bit = slave_word[15 - slave_k];
    end
    assign miso0 = sel_loop ? mosi0 : slave_bit;

    // Mode 0: rising SCLK is the sampling edge, capture MOSI there
    always @(posedge spi_clk0) begin
        rise_cnt0 <= rise_cnt0 + 1;
        mosi_smp0 <= {mosi_smp0[6:0], mosi0};
    end

    always @(negedge spi_clk0) fall_cnt0 <= fall_cnt0 + 1;

    // Mode 3: rising SCLK is the trailing (sampling) edge
    always @(posedge spi_clk3) mosi_smp3 <= {mosi_smp3[6:0], mosi3};

    // Receive strobe monitors, sampled away from the active clock edge
    always @(negedge clk) begin
        if (rx_dv0 === 1'b1) begin
            dv_cnt0  <= dv_cnt0 + 1;
            rx_prev0 <= rx_last0;
            rx_last0 <= rx_byte0;
        end
        if (rx_dv3 === 1'b1) dv_cnt3 <= dv_cnt3 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send0(input logic [7:0] b);
        tx_byte0 = b;
        tx_dv0   = 1'b1;
        @(negedge clk);
        tx_dv0   = 1'b0;
    endtask

    task automatic wait_ready0(output int low_cycles);
        int n;
        n = 0;
        while (rdy0 !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        low_cycles = n;
        check("ready0_reassert", {31'd0, rdy0}, 32'd1);
    endtask

    initial begin
        int low, rb, db, eb, n;
        logic spi_clk_at_7;

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready0",   {31'd0, rdy0},     32'd0);
        check("rst_rxdv0",    {31'd0, rx_dv0},   32'd0);
        check("rst_rxbyte0",  {24'd0, rx_byte0}, 32'h00);
        check("rst_mosi0",    {31'd0, mosi0},    32'd0);
        check("rst_sclk0",    {31'd0, spi_clk0}, 32'd0);
        check("rst_sclk3",    {31'd0, spi_clk3}, 32'd1);
        check("rst_ready3",   {31'd0, rdy3},     32'd0);

        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_ready0", {31'd0, rdy0}, 32'd1);
        check("rel_ready3", {31'd0, rdy3}, 32'd1);
        @(negedge clk);

        // ---------------- mode 0, send 0xC1 ----------------
        sel_loop = 1'b1;
        rb = rise_cnt0; db = dv_cnt0;
        send0(8'hC1);
        check("c1_mosi_bit7", {31'd0, mosi0}, 32'd1);
        check("c1_ready_low", {31'd0, rdy0},  32'd0);
        wait_ready0(low);
        repeat (2) @(negedge clk);
        check("c1_low_ge64", {31'd0, (low >= 64)}, 32'd1);
        check("c1_rises",    32'(rise_cnt0 - rb),  32'd8);
        check("c1_mosi",     {24'd0, mosi_smp0},   32'hC1);
        check("c1_rxdv",     32'(dv_cnt0 - db),    32'd1);
        check("c1_sclk_idle", {31'd0, spi_clk0},   32'd0);

        // ---------------- loopback 0xBE ----------------
        db = dv_cnt0;
        send0(8'hBE);
        wait_ready0(low);
        repeat (2) @(negedge clk);
        check("be_rxdv",   32'(dv_cnt0 - db),  32'd1);
        check("be_rxbyte", {24'd0, rx_byte0},  32'hBE);

        // ---------------- slave 0x54/0x33, back-to-back ----------------
        sel_loop  = 1'b0;
        fall_base = fall_cnt0;
        db = dv_cnt0; rb = rise_cnt0;
        send0(8'hAA);
        wait_ready0(low);
        send0(8'hBB);
        wait_ready0(low);
        repeat (4) @(negedge clk);
        check("b2b_rxdv",    32'(dv_cnt0 - db),   32'd2);
        check("b2b_first",   {24'd0, rx_prev0},   32'h54);
        check("b2b_second",  {24'd0, rx_last0},   32'h33);
        check("b2b_hold",    {24'd0, rx_byte0},   32'h33);
        check("b2b_rises",   32'(rise_cnt0 - rb), 32'd16);
        check("b2b_mosi_bb", {24'd0, mosi_smp0},  32'hBB);

        // ---------------- DV ignored while busy ----------------
        sel_loop = 1'b1;
        db = dv_cnt0; rb = rise_cnt0;
        send0(8'hCC);
        repeat (20) @(negedge clk);
        send0(8'hEF);
        wait_ready0(low);
        repeat (2) @(negedge clk);
        check("ign_rises",  32'(rise_cnt0 - rb), 32'd8);
        check("ign_mosi",   {24'd0, mosi_smp0},  32'hCC);
        check("ign_rxdv",   32'(dv_cnt0 - db),   32'd1);
        check("ign_rxbyte", {24'd0, rx_byte0},   32'hCC);

        // ---------------- mode 3 loopback 0xDD ----------------
        check("m3_idle_high", {31'd0, spi_clk3}, 32'd1);
        db = dv_cnt3;
        tx_byte3 = 8'hDD; tx_dv3 = 1'b1;
        @(negedge clk);
        tx_dv3 = 1'b0;
        n = 0;
        while (rdy3 !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("m3_ready", {31'd0, rdy3}, 32'd1);
        repeat (2) @(negedge clk);
        check("m3_rxdv",   32'(dv_cnt3 - db), 32'd1);
        check("m3_rxbyte", {24'd0, rx_byte3}, 32'hDD);
        check("m3_mosi",   {24'd0, mosi_smp3}, 32'hDD);
        check("m3_idle_after", {31'd0, spi_clk3}, 32'd1);

        // ---------------- reset at edge 7 ----------------
        db = dv_cnt0;
        eb = rise_cnt0 + fall_cnt0;
        send0(8'h96);
        n = 0;
        while ((rise_cnt0 + fall_cnt0 - eb) < 7 && n < 500) begin
            @(negedge clk);
            n++;
        end
        spi_clk_at_7 = spi_clk0;
        check("abort_edge7_high", {31'd0, spi_clk_at_7}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_sclk_cpol", {31'd0, spi_clk0}, 32'd0);
        check("abort_ready",     {31'd0, rdy0},     32'd0);
        repeat (80) @(negedge clk);
        check("abort_no_rxdv",   32'(dv_cnt0 - db), 32'd0);
        check("abort_rxbyte",    {24'd0, rx_byte0}, 32'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_ready_rel", {31'd0, rdy0}, 32'd1);
        repeat (80) @(negedge clk);
        check("abort_still_no_rxdv", 32'(dv_cnt0 - db), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_core.md
SPI_MASTER_CORE -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter SPI_MODE, default 0, range 0-3; CPOL = SPI_MODE[1], CPHA = SPI_MODE[0].
REQ-002 SHALL have parameter CLKS_PER_HALF_BIT, default 4, minimum 2; i_Clk cycles per SPI clock half-period.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 i_Clk  input  1  system clock; all logic on rising edge.
REQ-005 i_Rst_L  input  1  asynchronous active-low reset.
REQ-006 i_TX_Byte  input  8  byte to transmit on MOSI, MSB first.
REQ-007 i_TX_DV  input  1  one-cycle start pulse qualifying i_TX_Byte.
REQ-008 o_TX_Ready  output  1  high when idle and able to accept i_TX_DV.
REQ-009 o_RX_DV  output  1  one-cycle pulse, o_RX_Byte valid.
REQ-010 o_RX_Byte  output  8  byte received on MISO.
REQ-011 o_SPI_Clk  output  1  SPI clock; idles at CPOL.
REQ-012 i_SPI_MISO  input  1  serial data from slave.
REQ-013 o_SPI_MOSI  output  1  serial data to slave.
REQ-014 Chip select is not part of this block; the system drives it externally.

Function
REQ-015 On i_TX_DV high with o_TX_Ready high, SHALL latch i_TX_Byte, deassert o_TX_Ready next cycle, load a 16-edge counter.
REQ-016 i_TX_DV while o_TX_Ready low SHALL be ignored; no byte latch, no transfer restart.
REQ-017 During a transfer, o_SPI_Clk SHALL toggle every CLKS_PER_HALF_BIT i_Clk cycles, exactly 16 edges (8 leading, 8 trailing); period = 2*CLKS_PER_HALF_BIT cycles.
REQ-018 Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
REQ-019 o_SPI_Clk SHALL be a registered output equal to CPOL whenever idle.
REQ-020 CPHA=0: bit 7 SHALL appear on o_SPI_MOSI the cycle after the accepted i_TX_DV; bits 6..0 update on trailing edges.
REQ-021 CPHA=1: bits 7..0 SHALL update on o_SPI_MOSI at successive leading edges.
REQ-022 i_SPI_MISO SHALL be sampled MSB first: on leading edges for CPHA=0, on trailing edges for CPHA=1.
REQ-023 o_RX_DV SHALL pulse high exactly one cycle, the cycle after bit 0 is sampled; o_RX_Byte holds the assembled byte from that pulse until the next pulse.
REQ-024 o_TX_Ready SHALL reassert the cycle after the 16th edge; a new i_TX_DV is then accepted with no extra gap.
REQ-025 o_SPI_MOSI SHALL hold its last driven value when idle.

Reset
REQ-026 While i_Rst_L low: o_TX_Ready=0, o_RX_DV=0, o_RX_Byte=0x00, o_SPI_MOSI=0, o_SPI_Clk=CPOL, edge counter=0, bit indices=7.
REQ-027 o_TX_Ready SHALL rise on the first i_Clk edge after reset release.
REQ-028 Reset asserted mid-transfer SHALL abort immediately, with no o_RX_DV pulse.

Structure
REQ-029 Single module with counters, shift logic and clock generator; no shared package required.
REQ-030 Edge-counter width SHALL be 5 bits; half-bit counter width SHALL be $clog2(2*CLKS_PER_HALF_BIT).
REQ-031 No sub-module required; a companion spi_slave is a separate block.

Verification
REQ-032 Mode 0, default params, send 0xC1 -> eight rising o_SPI_Clk edges sample MOSI 1,1,0,0,0,0,0,1; o_TX_Ready low for 64+ cycles.
REQ-033 Mode 0, MISO tied to MOSI, send 0xBE -> single o_RX_DV pulse, o_RX_Byte=0xBE.
REQ-034 Slave model returns 0x54, then 0x33; send 0xAA then 0xBB back-to-back on o_TX_Ready -> o_RX_Byte 0x54 then 0x33, exactly two o_RX_DV pulses.
REQ-035 Assert i_TX_DV with 0xEF mid-transfer of 0xCC -> ignored; only 0xCC shifted out.
REQ-036 SPI_MODE=3 -> o_SPI_Clk idles high; loopback 0xDD returns 0xDD.
REQ-037 Drop i_Rst_L at edge 7 -> o_SPI_Clk=CPOL at once; no o_RX_DV; o_TX_Ready high one cycle after release.
